mem_arbiter_n: RTL and testbench

//  Parametrised successor to the fixed two-client memory controller: arbitrates NUM_CH

---
 rtl/mem_arbiter_n.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_arbiter_n.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// rtl/mem_arbiter_n.sv - NUM_CH-channel arbiter onto a byte-serial 8-bit RAM bus
module mem_arbiter_n #(
  parameter int          NUM_CH   = 3,
  parameter int          ID_WIDTH = 4,
  parameter int          RR_MODE  = 0,
  parameter logic [31:0] IO_BASE  = 32'h30000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         io_buffer_full,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH-1:0]            req_we,
  input  logic [NUM_CH-1:0]            req_signed,
  input  logic [2*NUM_CH-1:0]          req_size,
  input  logic [32*NUM_CH-1:0]         req_addr,
  input  logic [32*NUM_CH-1:0]         req_wdata,
  input  logic [ID_WIDTH*NUM_CH-1:0]   req_id,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [NUM_CH-1:0]            resp_valid,
  output logic [31:0]                  resp_data,
  output logic [ID_WIDTH-1:0]          resp_id,
  output logic                         busy,
  input  logic [7:0]                   ram_din,
  output logic [7:0]                   ram_dout,
  output logic [31:0]                  ram_a,
  output logic                         ram_wr
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic [31:0]           addr_q, addr_d;
  logic [2:0]            nb_q, nb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  sgn_q, sgn_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic [31:0]           ram_a_q, ram_a_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic [NUM_CH-1:0]     req_ready_q, req_ready_d;
  logic [NUM_CH-1:0]     resp_valid_q, resp_valid_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;

  logic [31:0]           addr_arr  [NUM_CH];
  logic [31:0]           wdata_arr [NUM_CH];
  logic [1:0]            size_arr  [NUM_CH];
  logic [ID_WIDTH-1:0]   id_arr    [NUM_CH];

  logic [NUM_CH-1:0]     elig;
  logic [CW-1:0]         win;
  logic                  found;
  logic [31:0]           cap;
  logic                  stall;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[32*g +: 32];
    assign wdata_arr[g] = req_wdata[32*g +: 32];
    assign size_arr[g]  = req_size[2*g +: 2];
    assign id_arr[g]    = req_id[ID_WIDTH*g +: ID_WIDTH];
  end

  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    if (sz[1])      nbytes = 3'd4;
    else if (sz[0]) nbytes = 3'd2;
    else            nbytes = 3'd1;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [2:0] k);
    case (k)
      3'd0:    byte_sel = w[7:0];
      3'd1:    byte_sel = w[15:8];
      3'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] nb,
                                         input logic sgn);
    case (nb)
      3'd1:    extend = {{24{sgn & d[7]}}, d[7:0]};
      3'd2:    extend = {{16{sgn & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // A flush only kills reads, so pending writes stay eligible while it is high.
  assign elig = req_valid & (req_we | {NUM_CH{~flush}});

  // Fixed priority is round-robin with the search always starting at channel 0.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = ((RR_MODE != 0) ? int'(rr_q) : 0) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && elig[idx[CW-1:0]]) begin
        win   = idx[CW-1:0];
        found = 1'b1;
      end
    end
  end

  assign stall = io_buffer_full && (ram_a_q >= IO_BASE);

  // Read buffer with the byte now on ram_din merged in; the RAM answers one beat late.
  always_comb begin
    cap = rbuf_q;
    case (cnt_q)
      3'd1:    cap[7:0]   = ram_din;
      3'd2:    cap[15:8]  = ram_din;
      3'd3:    cap[23:16] = ram_din;
      3'd4:    cap[31:24] = ram_din;
      default: cap = rbuf_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    rr_d         = rr_q;
    addr_d       = addr_q;
    nb_d         = nb_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    sgn_d        = sgn_q;
    cnt_d        = cnt_q;
    rbuf_d       = rbuf_q;
    ram_a_d      = ram_a_q;
    ram_dout_d   = ram_dout_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;

    if (rdy) begin
      req_ready_d  = '0;
      resp_valid_d = '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            ch_d             = win;
            addr_d           = addr_arr[win];
            nb_d             = nbytes(size_arr[win]);
            wdata_d          = wdata_arr[win];
            id_d             = id_arr[win];
            sgn_d            = req_signed[win];
            cnt_d            = 3'd0;
            rbuf_d           = '0;
            ram_a_d          = addr_arr[win];
            ram_dout_d       = wdata_arr[win][7:0];
            req_ready_d[win] = 1'b1;
            state_d          = req_we[win] ? WRITE : READ;
            if (RR_MODE != 0)
              rr_d = (win == CW'(NUM_CH - 1)) ? '0 : win + CW'(1);
          end
        end
        READ: begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            rbuf_d = cap;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < nb_q)
              ram_a_d = addr_q + 32'(cnt_q) + 32'd1;
            if (cnt_q == nb_q) begin
              state_d            = DONE;
              resp_valid_d[ch_q] = 1'b1;
              resp_data_d        = extend(cap, nb_q, sgn_q);
              resp_id_d          = id_q;
            end
          end
        end
        WRITE: begin
          if (!stall) begin
            if (cnt_q + 3'd1 == nb_q) begin
              state_d            = DONE;
              resp_valid_d[ch_q] = 1'b1;
              resp_data_d        = '0;
              resp_id_d          = id_q;
            end else begin
              cnt_d      = cnt_q + 3'd1;
              ram_a_d    = addr_q + 32'(cnt_q) + 32'd1;
              ram_dout_d = byte_sel(wdata_q, cnt_q + 3'd1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      rr_q         <= '0;
      addr_q       <= '0;
      nb_q         <= '0;
      wdata_q      <= '0;
      id_q         <= '0;
      sgn_q        <= 1'b0;
      cnt_q        <= '0;
      rbuf_q       <= '0;
      ram_a_q      <= '0;
      ram_dout_q   <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      rr_q         <= rr_d;
      addr_q       <= addr_d;
      nb_q         <= nb_d;
      wdata_q      <= wdata_d;
      id_q         <= id_d;
      sgn_q        <= sgn_d;
      cnt_q        <= cnt_d;
      rbuf_q       <= rbuf_d;
      ram_a_q      <= ram_a_d;
      ram_dout_q   <= ram_dout_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // Write strobe is combinational so a freeze or a full IO buffer suppresses the beat at once.
  assign ram_wr     = (state_q == WRITE) && rdy && !stall;
  assign ram_a      = ram_a_q;
  assign ram_dout   = ram_dout_q;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb/tb_mem_arbiter_n.sv - directed-vector bench for mem_arbiter_n
module tb_mem_arbiter_n;
  localparam int NC = 3;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst, rdy, flush, io_full;
  logic [NC-1:0]    req_valid, req_we, req_signed;
  logic [2*NC-1:0]  req_size;
  logic [32*NC-1:0] req_addr, req_wdata;
  logic [IW*NC-1:0] req_id;
  logic [NC-1:0]    req_ready, resp_valid, rr_req_ready, rr_resp_valid;
  logic [31:0]      resp_data, rr_resp_data, ram_a, rr_ram_a;
  logic [IW-1:0]    resp_id, rr_resp_id;
  logic             busy, rr_busy, ram_wr, rr_ram_wr;
  logic [7:0]       ram_din, ram_dout, rr_ram_dout;
  logic [7:0]       mem [0:255];

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter_n #(.NUM_CH(NC), .ID_WIDTH(IW), .RR_MODE(0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_full),
    .req_valid(req_valid), .req_we(req_we), .req_signed(req_signed), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy), .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr));

  mem_arbiter_n #(.NUM_CH(NC), .ID_WIDTH(IW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_full),
    .req_valid(req_valid), .req_we(req_we), .req_signed(req_signed), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
    .req_ready(rr_req_ready), .resp_valid(rr_resp_valid), .resp_data(rr_resp_data),
    .resp_id(rr_resp_id), .busy(rr_busy), .ram_din(ram_din), .ram_dout(rr_ram_dout),
    .ram_a(rr_ram_a), .ram_wr(rr_ram_wr));

  always #5 clk = ~clk;

  // RAM stalls together with the core while rdy is low.
  always @(posedge clk) if (rdy) ram_din <= mem[ram_a[7:0]];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int ch, input logic we, input logic sgn, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] id);
    req_we[ch]             = we;
    req_signed[ch]         = sgn;
    req_size[2*ch +: 2]    = sz;
    req_addr[32*ch +: 32]  = addr;
    req_wdata[32*ch +: 32] = wd;
    req_id[IW*ch +: IW]    = id;
    req_valid[ch]          = 1'b1;
  endtask

  task automatic do_read(input string tag, input int ch, input logic [31:0] addr,
                         input logic [1:0] sz, input logic sgn, input logic [3:0] id,
                         input int n, input logic [31:0] exp);
    set_req(ch, 1'b0, sgn, sz, addr, 32'h0, id);
    step;
    check_vec({tag, "_ready"}, 32'(req_ready), 32'd1 << ch);
    req_valid = '0;
    repeat (n + 1) step;
    check_vec({tag, "_rvalid"}, 32'(resp_valid), 32'd1 << ch);
    check_vec({tag, "_rdata"}, resp_data, exp);
    check_vec({tag, "_rid"}, 32'(resp_id), 32'(id));
    step;
    check_vec({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] g_fix [4];
    logic [2:0] g_rr  [4];
    int nf, nr;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
    req_valid = '0; req_we = '0; req_signed = '0; req_size = '0;
    req_addr = '0; req_wdata = '0; req_id = '0; ram_din = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[5] = 8'h80; mem[16] = 8'h01; mem[17] = 8'h80;

    repeat (2) step;
    check_vec("rst_ready", 32'(req_ready), 32'd0);
    check_vec("rst_resp", 32'(resp_valid), 32'd0);
    check_vec("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_wr", 32'(ram_wr), 32'd0);
    check_vec("rst_a", ram_a, 32'd0);
    rst = 1'b0;
    step;

    // ch1 word read at 0x100
    set_req(1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 4'h5);
    step;
    check_vec("t1_ready", 32'(req_ready), 32'b010);
    check_vec("t1_a0", ram_a, 32'h100);
    check_vec("t1_busy", 32'(busy), 32'd1);
    req_valid = '0;
    for (int k = 1; k < 4; k++) begin
      step;
      check_vec("t1_a", ram_a, 32'h100 + 32'(k));
    end
    step;
    check_vec("t1_early", 32'(resp_valid), 32'd0);
    step;
    check_vec("t1_rvalid", 32'(resp_valid), 32'b010);
    check_vec("t1_rdata", resp_data, 32'h44332211);
    check_vec("t1_rid", 32'(resp_id), 32'h5);
    step;
    check_vec("t1_pulse", 32'(resp_valid), 32'd0);
    check_vec("t1_idle", 32'(busy), 32'd0);

    do_read("t2_sb", 0, 32'h5,  2'b00, 1'b1, 4'h3, 1, 32'hFFFFFF80);
    do_read("t2_ub", 2, 32'h5,  2'b00, 1'b0, 4'h4, 1, 32'h00000080);
    do_read("t2_uh", 0, 32'h10, 2'b01, 1'b0, 4'h9, 2, 32'h00008001);
    do_read("t2_sh", 1, 32'h10, 2'b01, 1'b1, 4'hA, 2, 32'hFFFF8001);

    // ch2 half write to IO space with the buffer full for three cycles
    set_req(2, 1'b1, 1'b0, 2'b01, 32'h30000, 32'h0000BEEF, 4'h7);
    io_full = 1'b1;
    step;
    check_vec("t3_ready", 32'(req_ready), 32'b100);
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step;
      check_vec("t3_stall_wr", 32'(ram_wr), 32'd0);
      check_vec("t3_stall_a", ram_a, 32'h30000);
    end
    step;
    io_full = 1'b0;
    #1;
    check_vec("t3_b0_wr", 32'(ram_wr), 32'd1);
    check_vec("t3_b0_a", ram_a, 32'h30000);
    check_vec("t3_b0_d", 32'(ram_dout), 32'hEF);
    step;
    check_vec("t3_b1_wr", 32'(ram_wr), 32'd1);
    check_vec("t3_b1_a", ram_a, 32'h30001);
    check_vec("t3_b1_d", 32'(ram_dout), 32'hBE);
    step;
    check_vec("t3_rvalid", 32'(resp_valid), 32'b100);
    check_vec("t3_rdata", resp_data, 32'd0);
    check_vec("t3_rid", 32'(resp_id), 32'h7);
    check_vec("t3_wr_end", 32'(ram_wr), 32'd0);
    step;
    check_vec("t3_once", 32'(resp_valid), 32'd0);

    // flush aborts ch0 read at beat 2; pending ch2 write follows
    set_req(0, 1'b0, 1'b0, 2'b10, 32'h20, 32'h0, 4'h1);
    set_req(2, 1'b1, 1'b0, 2'b00, 32'h40, 32'h5A, 4'h2);
    step;
    check_vec("t5_ready0", 32'(req_ready), 32'b001);
    req_valid[0] = 1'b0;
    step;
    step;
    check_vec("t5_beat2", ram_a, 32'h22);
    flush = 1'b1;
    step;
    flush = 1'b0;
    check_vec("t5_idle", 32'(busy), 32'd0);
    check_vec("t5_noresp", 32'(resp_valid), 32'd0);
    step;
    check_vec("t5_ready2", 32'(req_ready), 32'b100);
    check_vec("t5_noresp2", 32'(resp_valid), 32'd0);
    check_vec("t5_wr", 32'(ram_wr), 32'd1);
    check_vec("t5_a", ram_a, 32'h40);
    check_vec("t5_d", 32'(ram_dout), 32'h5A);
    req_valid = '0;
    step;
    check_vec("t5_rvalid", 32'(resp_valid), 32'b100);
    check_vec("t5_rid", 32'(resp_id), 32'h2);
    step;

    // async reset in the middle of a word write
    set_req(1, 1'b1, 1'b0, 2'b10, 32'h50, 32'h12345678, 4'h4);
    step;
    req_valid = '0;
    step;
    check_vec("t6_pre_a", ram_a, 32'h51);
    #1 rst = 1'b1;
    #1;
    check_vec("t6_wr", 32'(ram_wr), 32'd0);
    check_vec("t6_busy", 32'(busy), 32'd0);
    check_vec("t6_a", ram_a, 32'd0);
    check_vec("t6_dout", 32'(ram_dout), 32'd0);
    #1 rst = 1'b0;
    step;
    check_vec("t6_stay_idle", 32'(busy), 32'd0);

    // rdy low in the middle of a word read
    set_req(1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 4'h6);
    step;
    req_valid = '0;
    step;
    step;
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      check_vec("t6_frz_a", ram_a, 32'h102);
      check_vec("t6_frz_busy", 32'(busy), 32'd1);
      check_vec("t6_frz_resp", 32'(resp_valid), 32'd0);
    end
    rdy = 1'b1;
    repeat (3) step;
    check_vec("t6_res_rvalid", 32'(resp_valid), 32'b010);
    check_vec("t6_res_rdata", resp_data, 32'h44332211);
    check_vec("t6_res_rid", 32'(resp_id), 32'h6);
    step;

    // all three channels requesting byte reads continuously
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
    for (int i = 0; i < 4; i++) begin g_fix[i] = '0; g_rr[i] = '0; end
    nf = 0; nr = 0;
    set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 32'h1, 32'h0, 4'h1);
    set_req(2, 1'b0, 1'b0, 2'b00, 32'h2, 32'h0, 4'h2);
    for (int c = 0; c < 40 && (nf < 4 || nr < 4); c++) begin
      step;
      if (req_ready != '0 && nf < 4) begin g_fix[nf] = req_ready; nf++; end
      if (rr_req_ready != '0 && nr < 4) begin g_rr[nr] = rr_req_ready; nr++; end
    end
    req_valid = '0;
    check_vec("t4_fix0", 32'(g_fix[0]), 32'b001);
    check_vec("t4_fix1", 32'(g_fix[1]), 32'b001);
    check_vec("t4_fix2", 32'(g_fix[2]), 32'b001);
    check_vec("t4_rr0", 32'(g_rr[0]), 32'b001);
    check_vec("t4_rr1", 32'(g_rr[1]), 32'b010);
    check_vec("t4_rr2", 32'(g_rr[2]), 32'b100);
    check_vec("t4_rr3", 32'(g_rr[3]), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
